cpu_trace_checker: RTL
======================

// Module: cpu_trace_checker
// PURPOSE
//  Streaming checker for CPU trace lines, one ASCII char per accepted beat:
//  '^'TIME'@'PC':'{' '}('$'GRF{' '} | '*'ADDR{' '})'<''='{' '}DATA'#'.
//  Parametrised successor of the fixed-format checker: field widths, legal ranges and
//  upper-case hex are configurable, input has a valid qualifier, and parsed fields are exported.
//  Sits between the UART/trace char source and the judge scoreboard.
// PARAMETERS
//  TIME_DIGITS  4        max decimal digits of TIME (min 1)
//  GRF_DIGITS   4        max decimal digits of GRF (min 1)
//  ADDR_DIGITS  8        exact hex digits of PC and ADDR
//  DATA_DIGITS  8        max hex digits of DATA (min 1)
//  GRF_MAX      31       highest legal register number
//  PC_LO/PC_HI  32'h3000/32'h4fff   legal PC range, inclusive
//  AD_LO/AD_HI  32'h0000/32'h2fff   legal ADDR range, inclusive
//  ALLOW_UPPER  0        1: 'A'-'F' accepted as hex digits as well as 'a'-'f'
// PORTS
//  clk          in   1    clock
//  reset        in   1    synchronous, active-high
//  char_valid   in   1    char is consumed only when high; low = all state holds
//  char         in   8    ASCII input
//  freq         in   16   clock-frequency code (power of two, >=2)
//  format_type  out  2    00 none, 01 register line, 10 memory line
//  error_code   out  4    error bits of the completed line; 0 when format_type==00
//  line_time    out  16   parsed TIME of the completed line
//  line_pc      out  32   parsed PC
//  line_target  out  32   GRF number (zero-extended) or ADDR
//  line_data    out  32   parsed DATA (right-aligned)
//  line_count   out  16   valid lines seen (CHECKER_STATS_EN)
//  err_count    out  16   valid lines with error_code!=0 (CHECKER_STATS_EN)
// BEHAVIOUR
//  - Reset: state IDLE, all outputs and field registers 0.
//  - States: IDLE, T0, TIME, P0, PC, SP, GRF0, GRF, ADR0, ADR, SP2, LT, EQ, DATA, DONE.
//  - '^' accepted in ANY state -> T0 with fields and error cleared (restart, no output).
//  - Any char not legal for the current state -> IDLE (line discarded silently).
//  - TIME/GRF/DATA: first digit from *0 state, extra digits until count limit; one digit past
//    the limit -> IDLE. PC/ADDR: terminator (':' / ' ' or '<') accepted only after exactly
//    ADDR_DIGITS digits, else IDLE. Accumulate with shift (x10 or x16) + digit, full width.
//  - SP: spaces loop; '$' -> GRF0 (type reg), '*' -> ADR0 (type mem). GRF/ADR end on ' '
//    (-> SP2, spaces loop) or '<' (-> LT). LT needs '=' -> EQ; EQ skips spaces, hex -> DATA.
//  - DATA: '#' -> DONE. DONE lasts exactly one accepted beat or until next char_valid.
//  - Error bits, evaluated on final field values (explicit parentheses, no precedence traps):
//    [0] ((line_time<<1) & (freq-1)) != 0, computed 17 bits wide
//    [1] PC outside [PC_LO,PC_HI] or PC[1:0]!=0
//    [2] mem line: ADDR outside [AD_LO,AD_HI] or ADDR[1:0]!=0
//    [3] reg line: GRF > GRF_MAX
//  - format_type/error_code combinational from state==DONE; line_* registered, stable while
//    DONE and held until the next '^'-start clears them. Latency: '#' beat -> outputs next cycle.
//  - DONE + '^' -> T0 (back-to-back lines, no idle beat required).
//  - reset mid-line -> IDLE; partial line never reported.
// CONFIGURATION
//  CHECKER_STATS_EN defined: line_count increments on each entry to DONE; err_count also
//  increments when error_code!=0; both saturate at 16'hFFFF; reset to 0.
//  Not defined: line_count and err_count tied to 16'h0, no counter logic.
// TESTING
//  "^10@00003000: $1 <= 0000abcd#", freq=2 -> format 01, err 0, line_data=32'h0000abcd
//  "^3@00003002: *00000010 <=   12#", freq=4 -> format 10, err 4'b0011 (time, pc misaligned)
//  "^12345@..." with TIME_DIGITS=4 -> IDLE, format stays 00; next good line reports normally
//  "^1@0000300^2@00003000: $40<=1#" -> restart at 2nd '^', err 4'b1000 (GRF 40>31)
//  char_valid low for 5 cycles mid-line -> identical result to contiguous stream
//  two good lines back-to-back, 2nd with err -> line_count=2, err_count=1 (STATS_EN)

Source files
------------

// File: rtl/cpu_trace_checker_if.sv
// -----------------------------------------------------------------------------
// cpu_trace_checker_if
// Purpose : bundles the character stream from the trace source and the
//           per-line results returned to the judge scoreboard.
// Signals :
//   char_valid  source -> checker   qualifies char; low means nothing consumed
//   char[7:0]   source -> checker   ASCII character
//   freq[15:0]  source -> checker   clock-frequency code (power of two, >= 2)
//   format_type checker -> judge    00 none, 01 register line, 10 memory line
//   error_code  checker -> judge    error bits of the completed line
//   line_time / line_pc / line_target / line_data   parsed fields
//   line_count / err_count          line statistics (zero when stats disabled)
// Modports: master = trace source / judge side, slave = checker side.
// -----------------------------------------------------------------------------
interface cpu_trace_checker_if;
    logic        char_valid;
    logic [7:0]  char;
    logic [15:0] freq;
    logic [1:0]  format_type;
    logic [3:0]  error_code;
    logic [15:0] line_time;
    logic [31:0] line_pc;
    logic [31:0] line_target;
    logic [31:0] line_data;
    logic [15:0] line_count;
    logic [15:0] err_count;

    modport master (
        output char_valid, char, freq,
        input  format_type, error_code, line_time, line_pc,
        input  line_target, line_data, line_count, err_count
    );

    modport slave (
        input  char_valid, char, freq,
        output format_type, error_code, line_time, line_pc,
        output line_target, line_data, line_count, err_count
    );
endinterface

// File: rtl/cpu_trace_checker.sv
// -----------------------------------------------------------------------------
// cpu_trace_checker
// Purpose : streaming checker for CPU trace lines of the form
//             ^TIME@PC:{ }($GRF{ } | *ADDR{ })<={ }DATA#
//           one ASCII character per accepted beat. A completed line is
//           reported for as long as the FSM rests in DONE; malformed lines
//           are dropped silently.
// Ports   :
//   clk    in  clock
//   reset  in  synchronous, active-high
//   bus    slave modport of cpu_trace_checker_if (char stream in, results out)
// Config  : define CHECKER_STATS_EN to build the saturating line_count /
//           err_count statistics; otherwise both outputs are tied to zero.
// -----------------------------------------------------------------------------
module cpu_trace_checker #(
    parameter int          TIME_DIGITS = 4,
    parameter int          GRF_DIGITS  = 4,
    parameter int          ADDR_DIGITS = 8,
    parameter int          DATA_DIGITS = 8,
    parameter int          GRF_MAX     = 31,
    parameter logic [31:0] PC_LO       = 32'h0000_3000,
    parameter logic [31:0] PC_HI       = 32'h0000_4fff,
    parameter logic [31:0] AD_LO       = 32'h0000_0000,
    parameter logic [31:0] AD_HI       = 32'h0000_2fff,
    parameter int          ALLOW_UPPER = 0
) (
    input  logic               clk,
    input  logic               reset,
    cpu_trace_checker_if.slave bus
);

    localparam logic [7:0] CH_CARET = 8'h5E;  // '^'
    localparam logic [7:0] CH_AT    = 8'h40;  // '@'
    localparam logic [7:0] CH_COLON = 8'h3A;  // ':'
    localparam logic [7:0] CH_SPACE = 8'h20;  // ' '
    localparam logic [7:0] CH_DOLL  = 8'h24;  // '$'
    localparam logic [7:0] CH_STAR  = 8'h2A;  // '*'
    localparam logic [7:0] CH_LT    = 8'h3C;  // '<'
    localparam logic [7:0] CH_EQ    = 8'h3D;  // '='
    localparam logic [7:0] CH_HASH  = 8'h23;  // '#'

    localparam logic [7:0] TIME_LIM = 8'(TIME_DIGITS);
    localparam logic [7:0] GRF_LIM  = 8'(GRF_DIGITS);
    localparam logic [7:0] ADDR_LIM = 8'(ADDR_DIGITS);
    localparam logic [7:0] DATA_LIM = 8'(DATA_DIGITS);

    typedef enum logic [3:0] {
        S_IDLE, S_T0, S_TIME, S_P0, S_PC, S_SP, S_GRF0, S_GRF,
        S_ADR0, S_ADR, S_SP2, S_LT, S_EQ, S_DATA, S_DONE
    } state_t;

    // ---------------------------------------------------------------------
    // Character classification helpers
    // ---------------------------------------------------------------------
    function automatic logic is_dec(input logic [7:0] c);
        return (c >= 8'h30) && (c <= 8'h39);
    endfunction

    function automatic logic is_lower_hex(input logic [7:0] c);
        return (c >= 8'h61) && (c <= 8'h66);
    endfunction

    function automatic logic is_upper_hex(input logic [7:0] c);
        return (c >= 8'h41) && (c <= 8'h46);
    endfunction

    function automatic logic is_hex(input logic [7:0] c);
        return is_dec(c) || is_lower_hex(c) ||
               ((ALLOW_UPPER != 0) && is_upper_hex(c));
    endfunction

    function automatic logic [3:0] hex_val(input logic [7:0] c);
        logic [7:0] v;
        if (is_dec(c))
            v = c - 8'h30;
        else if (is_lower_hex(c))
            v = c - 8'h57;
        else
            v = c - 8'h37;
        return v[3:0];
    endfunction

    // Range test written as an offset compare so a zero lower bound never
    // turns into an always-false unsigned "< 0" comparison.
    function automatic logic in_range(input logic [31:0] v,
                                      input logic [31:0] lo,
                                      input logic [31:0] hi);
        return (v - lo) <= (hi - lo);
    endfunction

    function automatic logic [3:0] calc_err(input logic [15:0] t,
                                            input logic [31:0] pc,
                                            input logic [31:0] tgt,
                                            input logic        mem,
                                            input logic [15:0] f);
        logic [16:0] t2;
        logic [16:0] fmask;
        logic [3:0]  e;
        t2    = {1'b0, t} << 1;
        fmask = {1'b0, f} - 17'd1;
        e[0]  = (t2 & fmask) != 17'd0;
        e[1]  = (!in_range(pc, PC_LO, PC_HI)) || (pc[1:0] != 2'b00);
        e[2]  = mem && ((!in_range(tgt, AD_LO, AD_HI)) || (tgt[1:0] != 2'b00));
        e[3]  = (!mem) && (tgt > 32'(GRF_MAX));
        return e;
    endfunction

    // ---------------------------------------------------------------------
    // Registers
    // ---------------------------------------------------------------------
    state_t      r_state;
    logic [7:0]  r_cnt;        // digits accepted in the current field
    logic        r_mem;        // current line is a memory line
    logic [15:0] r_time;
    logic [31:0] r_pc;
    logic [31:0] r_target;
    logic [31:0] r_data;
    // Snapshot of the last completed line, presented while in DONE
    logic        r_line_mem;
    logic [15:0] r_line_time;
    logic [31:0] r_line_pc;
    logic [31:0] r_line_target;
    logic [31:0] r_line_data;

    logic [7:0]  w_c;
    logic        w_dec;
    logic        w_hex;
    logic [3:0]  w_dig;
    logic        w_done;

    assign w_c    = bus.char;
    assign w_dec  = is_dec(w_c);
    assign w_hex  = is_hex(w_c);
    assign w_dig  = hex_val(w_c);
    assign w_done = (r_state == S_DONE);

    // ---------------------------------------------------------------------
    // Parser FSM
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_cnt         <= 8'd0;
            r_mem         <= 1'b0;
            r_time        <= 16'd0;
            r_pc          <= 32'd0;
            r_target      <= 32'd0;
            r_data        <= 32'd0;
            r_line_mem    <= 1'b0;
            r_line_time   <= 16'd0;
            r_line_pc     <= 32'd0;
            r_line_target <= 32'd0;
            r_line_data   <= 32'd0;
        end else if (bus.char_valid) begin
            if (w_c == CH_CARET) begin
                // A caret restarts parsing from any state and wipes the
                // previous line's report.
                r_state       <= S_T0;
                r_cnt         <= 8'd0;
                r_mem         <= 1'b0;
                r_time        <= 16'd0;
                r_pc          <= 32'd0;
                r_target      <= 32'd0;
                r_data        <= 32'd0;
                r_line_mem    <= 1'b0;
                r_line_time   <= 16'd0;
                r_line_pc     <= 32'd0;
                r_line_target <= 32'd0;
                r_line_data   <= 32'd0;
            end else begin
                case (r_state)
                    S_T0: begin
                        if (w_dec) begin
                            r_time  <= {12'd0, w_dig};
                            r_cnt   <= 8'd1;
                            r_state <= S_TIME;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                    S_TIME: begin
                        if (w_dec && (r_cnt != TIME_LIM)) begin
                            r_time <= (r_time * 16'd10) + {12'd0, w_dig};
                            r_cnt  <= r_cnt + 8'd1;
                        end else if (w_c == CH_AT) begin
                            r_state <= S_P0;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                    S_P0: begin
                        if (w_hex) begin
                            r_pc    <= {28'd0, w_dig};
                            r_cnt   <= 8'd1;
                            r_state <= S_PC;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                    S_PC: begin
                        if (w_hex && (r_cnt != ADDR_LIM)) begin
                            r_pc  <= {r_pc[27:0], w_dig};
                            r_cnt <= r_cnt + 8'd1;
                        end else if ((w_c == CH_COLON) && (r_cnt == ADDR_LIM)) begin
                            r_state <= S_SP;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                    S_SP: begin
                        if (w_c == CH_DOLL) begin
                            r_mem   <= 1'b0;
                            r_state <= S_GRF0;
                        end else if (w_c == CH_STAR) begin
                            r_mem   <= 1'b1;
                            r_state <= S_ADR0;
                        end else if (w_c != CH_SPACE) begin
                            r_state <= S_IDLE;
                        end
                    end
                    S_GRF0: begin
                        if (w_dec) begin
                            r_target <= {28'd0, w_dig};
                            r_cnt    <= 8'd1;
                            r_state  <= S_GRF;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                    S_GRF: begin
                        if (w_dec && (r_cnt != GRF_LIM)) begin
                            r_target <= (r_target * 32'd10) + {28'd0, w_dig};
                            r_cnt    <= r_cnt + 8'd1;
                        end else if (w_c == CH_SPACE) begin
                            r_state <= S_SP2;
                        end else if (w_c == CH_LT) begin
                            r_state <= S_LT;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                    S_ADR0: begin
                        if (w_hex) begin
                            r_target <= {28'd0, w_dig};
                            r_cnt    <= 8'd1;
                            r_state  <= S_ADR;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                    S_ADR: begin
                        if (w_hex && (r_cnt != ADDR_LIM)) begin
                            r_target <= {r_target[27:0], w_dig};
                            r_cnt    <= r_cnt + 8'd1;
                        end else if ((w_c == CH_SPACE) && (r_cnt == ADDR_LIM)) begin
                            r_state <= S_SP2;
                        end else if ((w_c == CH_LT) && (r_cnt == ADDR_LIM)) begin
                            r_state <= S_LT;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                    S_SP2: begin
                        if (w_c == CH_LT)
                            r_state <= S_LT;
                        else if (w_c != CH_SPACE)
                            r_state <= S_IDLE;
                    end
                    S_LT: begin
                        r_state <= (w_c == CH_EQ) ? S_EQ : S_IDLE;
                    end
                    S_EQ: begin
                        if (w_hex) begin
                            r_data  <= {28'd0, w_dig};
                            r_cnt   <= 8'd1;
                            r_state <= S_DATA;
                        end else if (w_c != CH_SPACE) begin
                            r_state <= S_IDLE;
                        end
                    end
                    S_DATA: begin
                        if (w_hex && (r_cnt != DATA_LIM)) begin
                            r_data <= {r_data[27:0], w_dig};
                            r_cnt  <= r_cnt + 8'd1;
                        end else if (w_c == CH_HASH) begin
                            r_line_mem    <= r_mem;
                            r_line_time   <= r_time;
                            r_line_pc     <= r_pc;
                            r_line_target <= r_target;
                            r_line_data   <= r_data;
                            r_state       <= S_DONE;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                    // IDLE and DONE accept only a caret, handled above
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    // ---------------------------------------------------------------------
    // Result outputs: qualifiers follow DONE, fields are the snapshot
    // ---------------------------------------------------------------------
    assign bus.format_type = w_done ? (r_line_mem ? 2'b10 : 2'b01) : 2'b00;
    assign bus.error_code  = w_done ? calc_err(r_line_time, r_line_pc, r_line_target,
                                               r_line_mem, bus.freq)
                                    : 4'd0;
    assign bus.line_time   = r_line_time;
    assign bus.line_pc     = r_line_pc;
    assign bus.line_target = r_line_target;
    assign bus.line_data   = r_line_data;

`ifdef CHECKER_STATS_EN
    logic [15:0] r_line_count;
    logic [15:0] r_err_count;
    logic        w_enter_done;
    logic [3:0]  w_err_next;

    // Error bits of the line about to complete, from the live field values
    assign w_enter_done = bus.char_valid && (r_state == S_DATA) && (w_c == CH_HASH);
    assign w_err_next   = calc_err(r_time, r_pc, r_target, r_mem, bus.freq);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_line_count <= 16'd0;
            r_err_count  <= 16'd0;
        end else if (w_enter_done) begin
            if (r_line_count != 16'hFFFF)
                r_line_count <= r_line_count + 16'd1;
            if ((w_err_next != 4'd0) && (r_err_count != 16'hFFFF))
                r_err_count <= r_err_count + 16'd1;
        end
    end

    assign bus.line_count = r_line_count;
    assign bus.err_count  = r_err_count;
`else
    assign bus.line_count = 16'h0;
    assign bus.err_count  = 16'h0;
`endif

endmodule
